// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-keeping slice.
package clock_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // Operating modes, also driven straight out on the mode port
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    // Two-digit field limits, written as decimal values
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with wrap at a programmable maximum (tens/units).
module bcd2_counter
    import clock_pkg::*;
#(
    parameter int MAX_TENS  = 5,
    parameter int MAX_UNITS = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic       clr_field,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       wrap
);

    localparam bcd_t MT = bcd_t'(MAX_TENS);
    localparam bcd_t MU = bcd_t'(MAX_UNITS);

    bcd_t tens_q, tens_d;
    bcd_t units_q, units_d;
    logic at_max;

    assign at_max = (tens_q == MT) && (units_q == MU);
    assign wrap   = inc && at_max;
    assign tens   = tens_q;
    assign units  = units_q;

    // Per-digit BCD increment: units 9->0 carries into tens, full maximum wraps to 00
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clr_field) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d  = '0;
                units_d = '0;
            end else if (units_q == bcd_t'(9)) begin
                tens_d  = tens_q + bcd_t'(1);
                units_d = '0;
            end else begin
                units_d = units_q + bcd_t'(1);
            end
        end
    end

    // Digit registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping controller: 1 Hz prescaler, run/set mode FSM, button edge
// detection, blink blanking and the cascaded sec/min/hour BCD counters.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hour_h,
    output logic [3:0] hour_l,
    output logic [3:0] min_h,
    output logic [3:0] min_l,
    output logic [3:0] sec_h,
    output logic [3:0] sec_l,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       tick_1hz,
    output logic       day_carry
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);

    mode_e         state_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          mode_hist_q, inc_hist_q;
    logic          tick_q, day_q, blank_hour_q, blank_min_q;

    logic presc_last, mode_ev, inc_ev, run, exit_set;
    logic sec_inc, min_inc, hour_inc;
    logic sec_wrap, min_wrap, hour_wrap;

    assign presc_last = (presc_q == P_LAST);
    assign mode_ev    = btn_mode & ~mode_hist_q;
    // A simultaneous mode event swallows the increment
    assign inc_ev     = btn_inc & ~inc_hist_q & ~mode_ev;
    assign run        = (state_q == MODE_RUN);
    // Leaving SET_MIN restarts the second so the first tick is a full period away
    assign exit_set   = mode_ev && (state_q == MODE_SET_MIN);

    assign sec_inc  = run && presc_last;
    assign min_inc  = (run && sec_wrap) || ((state_q == MODE_SET_MIN) && inc_ev);
    assign hour_inc = (run && min_wrap) || ((state_q == MODE_SET_HOUR) && inc_ev);

    // Prescaler next count: free-running, restarted on return to RUN
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (exit_set || presc_last) begin
            presc_d = '0;
        end
    end

    // Prescaler and button history (history resets high to mask held buttons)
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q     <= '0;
            mode_hist_q <= 1'b1;
            inc_hist_q  <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            mode_hist_q <= btn_mode;
            inc_hist_q  <= btn_inc;
        end
    end

    // Mode FSM with registered blink flags, one cycle behind the prescaler compare
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= MODE_RUN;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
        end else begin
            if (mode_ev) begin
                case (state_q)
                    MODE_RUN:      state_q <= MODE_SET_HOUR;
                    MODE_SET_HOUR: state_q <= MODE_SET_MIN;
                    default:       state_q <= MODE_RUN;
                endcase
            end
            blank_hour_q <= (state_q == MODE_SET_HOUR) && (presc_q >= P_HALF);
            blank_min_q  <= (state_q == MODE_SET_MIN) && (presc_q >= P_HALF);
        end
    end

    // One-cycle strobes: second tick and midnight rollover
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tick_q <= 1'b0;
            day_q  <= 1'b0;
        end else begin
            tick_q <= presc_last;
            day_q  <= run && hour_wrap;
        end
    end

    bcd2_counter #(.MAX_TENS(SEC_MAX / 10), .MAX_UNITS(SEC_MAX % 10)) u_sec (
        .clk       (clk),
        .clr       (clr),
        .inc       (sec_inc),
        .clr_field (exit_set),
        .tens      (sec_h),
        .units     (sec_l),
        .wrap      (sec_wrap)
    );

    bcd2_counter #(.MAX_TENS(MIN_MAX / 10), .MAX_UNITS(MIN_MAX % 10)) u_min (
        .clk       (clk),
        .clr       (clr),
        .inc       (min_inc),
        .clr_field (1'b0),
        .tens      (min_h),
        .units     (min_l),
        .wrap      (min_wrap)
    );

    bcd2_counter #(.MAX_TENS(HOUR_MAX / 10), .MAX_UNITS(HOUR_MAX % 10)) u_hour (
        .clk       (clk),
        .clr       (clr),
        .inc       (hour_inc),
        .clr_field (1'b0),
        .tens      (hour_h),
        .units     (hour_l),
        .wrap      (hour_wrap)
    );

    assign mode       = state_q;
    assign blank_hour = blank_hour_q;
    assign blank_min  = blank_min_q;
    assign tick_1hz   = tick_q;
    assign day_carry  = day_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with a queue-based expectation scoreboard.
module tb_clock_time_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hour_h, hour_l, min_h, min_l, sec_h, sec_l;
    logic [1:0] mode;
    logic       blank_hour, blank_min, tick_1hz, day_carry;

    always #5 clk = ~clk;

    clock_time_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .hour_h     (hour_h),
        .hour_l     (hour_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .sec_h      (sec_h),
        .sec_l      (sec_l),
        .mode       (mode),
        .blank_hour (blank_hour),
        .blank_min  (blank_min),
        .tick_1hz   (tick_1hz),
        .day_carry  (day_carry)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt;
    int   dc_cnt;
    int   eh, em, es;

    // Pulse counters since the last clr, sampled on the inactive edge
    always @(negedge clk or posedge clr) begin
        if (clr) begin
            tick_cnt <= 0;
            dc_cnt   <= 0;
        end else begin
            tick_cnt <= tick_cnt + int'(tick_1hz);
            dc_cnt   <= dc_cnt + int'(day_carry);
        end
    end

    function automatic logic [31:0] tbcd(input int h, input int m, input int s);
        return {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] cur_time();
        return {8'h00, hour_h, hour_l, min_h, min_l, sec_h, sec_l};
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        cyc(1);
        btn_inc = 1'b0;
        cyc(1);
    endtask

    task automatic press_mode(input int exp_mode, input string t);
        btn_mode = 1'b1;
        cyc(1);
        push(t, 32'(exp_mode));
        check_next({30'd0, mode});
        btn_mode = 1'b0;
        cyc(1);
    endtask

    task automatic blink_window(input int exp_bh, input int exp_bm, input string t);
        int bh, bm;
        bh = 0;
        bm = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            cyc(1);
            bh += int'(blank_hour);
            bm += int'(blank_min);
        end
        push({t, "_blank_hour"}, 32'(exp_bh));
        check_next(32'(bh));
        push({t, "_blank_min"}, 32'(exp_bm));
        check_next(32'(bm));
    endtask

    initial begin
        // 1: reset values, then a mode button held across release
        clr = 1'b1;
        cyc(2);
        push("rst_time", tbcd(0, 0, 0));             check_next(cur_time());
        push("rst_mode", 32'd0);                     check_next({30'd0, mode});
        push("rst_strobes", 32'd0);                  check_next({28'd0, blank_hour, blank_min, tick_1hz, day_carry});
        btn_mode = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(3);
        push("held_mode_no_event", 32'd0);           check_next({30'd0, mode});
        btn_mode = 1'b0;
        cyc(1);

        // 2: sixty seconds of RUN from a clean reset
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(59 * TD);
        push("run_59s", tbcd(0, 0, 59));             check_next(cur_time());
        cyc(TD);
        push("run_60s_carry", tbcd(0, 1, 0));        check_next(cur_time());
        #2;
        push("tick_count_60", 32'd60);               check_next(32'(tick_cnt));
        eh = 0; em = 1; es = 0;

        // 3: SET_HOUR, 25 increments wrap through 23->00
        press_mode(1, "enter_set_hour");
        for (int i = 0; i < 25; i++) begin
            press_inc();
            eh = (eh + 1) % 24;
        end
        push("set_hour_25", tbcd(eh, em, es));       check_next(cur_time());
        #2;
        push("set_no_day_carry", 32'd0);             check_next(32'(dc_cnt));
        blink_window(TD, 0, "set_hour");

        // 4: set 23:59, return to RUN, roll over midnight
        for (int i = 0; i < 22; i++) begin
            press_inc();
            eh = (eh + 1) % 24;
        end
        press_mode(2, "enter_set_min");
        for (int i = 0; i < 58; i++) begin
            press_inc();
            em = (em + 1) % 60;
        end
        push("set_2359", tbcd(eh, em, es));          check_next(cur_time());
        blink_window(0, TD, "set_min");
        btn_mode = 1'b1;
        cyc(1);
        btn_mode = 1'b0;
        push("exit_mode_run", 32'd0);                check_next({30'd0, mode});
        push("exit_sec_cleared", tbcd(23, 59, 0));   check_next(cur_time());
        cyc(60 * TD - 1);
        push("pre_midnight", tbcd(23, 59, 59));      check_next(cur_time());
        push("pre_midnight_dc", 32'd0);              check_next({31'd0, day_carry});
        cyc(1);
        push("midnight_time", tbcd(0, 0, 0));        check_next(cur_time());
        push("midnight_dc", 32'd1);                  check_next({31'd0, day_carry});
        cyc(1);
        push("post_midnight_dc", 32'd0);             check_next({31'd0, day_carry});
        #2;
        push("dc_count_1", 32'd1);                   check_next(32'(dc_cnt));

        // 5: simultaneous mode and inc in SET_HOUR
        press_mode(1, "enter_set_hour2");
        eh = 0; em = 0; es = 0;
        for (int i = 0; i < 5; i++) begin
            press_inc();
            eh = eh + 1;
        end
        push("set_hour_05", tbcd(eh, em, es));       check_next(cur_time());
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cyc(1);
        push("both_mode", 32'd2);                    check_next({30'd0, mode});
        push("both_time", tbcd(5, 0, 0));            check_next(cur_time());
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(1);

        // 6: clr in the middle of an increment press in SET_MIN
        for (int i = 0; i < 37; i++) begin
            press_inc();
            em = em + 1;
        end
        push("set_min_37", tbcd(5, 37, 0));          check_next(cur_time());
        btn_inc = 1'b1;
        cyc(1);
        push("inc_38", tbcd(5, 38, 0));              check_next(cur_time());
        #1;
        clr = 1'b1;
        #1;
        push("async_clr_time", tbcd(0, 0, 0));       check_next(cur_time());
        push("async_clr_mode", 32'd0);               check_next({30'd0, mode});
        cyc(1);
        clr = 1'b0;
        cyc(2 * TD);
        push("after_clr_run", tbcd(0, 0, 2));        check_next(cur_time());
        push("after_clr_mode", 32'd0);               check_next({30'd0, mode});
        #2;
        push("after_clr_ticks", 32'd2);              check_next(32'(tick_cnt));
        btn_inc = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
